uart_wb_master: RTL
===================

Name: uart_wb_master

Overview:
- Bridges the UART byte stream to a Wishbone classic master port.
- Assembles command frames from received bytes and issues single read or write bus cycles.
- Returns a status byte, plus read data, through the UART transmitter.
- Successor to the fixed-width UART decoder: address and data widths are parameters; bus timeout, inter-byte timeout and error reporting are new.

Parameters:
AW, 32, address width in bits; multiple of 8, range 8..32
DW, 32, data width in bits; multiple of 8, range 8..32
RX_TIMEOUT, 120000, idle cycles allowed between bytes of one frame (10 ms at 12 MHz)
WB_TIMEOUT, 255, cycles allowed waiting for ack/err before abort

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous reset, active low
i_rx_data  in  8  received byte
i_rx_stb  in  1  one-cycle pulse: i_rx_data valid
o_tx_data  out  8  byte to transmit
o_tx_stb  out  1  one-cycle pulse: send o_tx_data
i_tx_busy  in  1  transmitter busy
o_wb_cyc  out  1  Wishbone cycle
o_wb_stb  out  1  Wishbone strobe
o_wb_we  out  1  write enable
o_wb_addr  out  AW  address
o_wb_data  out  DW  write data
o_wb_sel  out  DW/8  byte select, always all ones
i_wb_data  in  DW  read data
i_wb_ack  in  1  acknowledge
i_wb_err  in  1  bus error
o_busy  out  1  high in any state other than IDLE
o_rx_drop  out  1  one-cycle pulse: byte discarded

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset is asynchronous. Asserting it mid-operation drops o_wb_cyc/o_wb_stb and o_tx_stb immediately. No response byte is sent.

Frame format (multi-byte fields MSB first):
- Write: 0x57, then AW/8 address bytes, then DW/8 data bytes.
- Read: 0x52, then AW/8 address bytes.

States:
- IDLE
  - 0x57 sets we=1; 0x52 sets we=0; either goes to ADDR.
  - Any other byte is ignored silently (no o_rx_drop).
- ADDR
  - Shift each byte into the address register.
  - After AW/8 bytes: go to DATA if we=1, else BUS.
- DATA
  - Shift bytes into the write-data register.
  - After DW/8 bytes, go to BUS.
- BUS
  - Assert o_wb_cyc and o_wb_stb, with o_wb_addr, o_wb_we, o_wb_data and o_wb_sel stable.
  - Hold until i_wb_ack, i_wb_err, or WB_TIMEOUT cycles counted from the first cycle of BUS.
  - Deassert cyc/stb the cycle after the terminating event.
  - On ack: capture i_wb_data if reading.
  - If ack and err are high together, err wins.
  - Timeout is treated as err.
  - Go to RESP.
- RESP
  - Send header byte: 0x4B on write ack, 0x44 on read ack, 0x45 on err/timeout.
  - On read ack, follow with DW/8 data bytes MSB first.
  - Return to IDLE after the last byte.

Inter-byte timeout:
- In ADDR/DATA, a counter resets on every i_rx_stb.
- On reaching RX_TIMEOUT, the partial frame is discarded and the state returns to IDLE. No bus cycle, no response.

Dropped bytes:
- Bytes arriving in BUS or RESP are discarded and pulse o_rx_drop in the same cycle.

TX handshake:
- o_tx_stb pulses for one cycle when a byte is pending and i_tx_busy=0.
- After each pulse, wait for i_tx_busy=1 or 2 cycles before sending again, so a lagging busy flag cannot cause a double send.
- Then wait for i_tx_busy=0 before the next pulse.
- o_tx_data is stable from the pulse until the next pulse.

Latency:
- The last frame byte's i_rx_stb produces o_wb_cyc=1 on the next cycle.

Test Plan:
- Write, ack after 3 cycles (AW=DW=32): bytes 57 00 00 10 00 DE AD BE EF -> one cycle with we=1, addr=0x00001000, data=0xDEADBEEF, sel=0xF; cyc high exactly 4 cycles; TX 0x4B.
- Read: bytes 52 00 00 10 04, slave acks with 0x12345678 -> we=0; TX 44 12 34 56 78 in order; no double sends with busy lagging 1 cycle.
- Bus error and timeout:
  - Read with i_wb_err -> TX 45.
  - Write with no ack -> cyc drops after 255 cycles; TX 45.
  - Ack and err in the same cycle -> TX 45.
- Inter-byte timeout: 57 00 then silence of RX_TIMEOUT (set 100 in bench) -> no cyc, no TX; following full read frame completes normally.
- Junk and overrun:
  - 0x41 in IDLE -> ignored, no o_rx_drop.
  - Byte during BUS -> o_rx_drop pulse; transaction result unchanged.
- Reset mid-cycle: assert i_rst_n=0 during BUS -> cyc/stb low asynchronously; after release, o_busy=0 and no TX byte.

Source files
------------

// File: rtl/uart_wb_master.sv
// UART byte stream to Wishbone classic master bridge.
// Frames: 0x57 addr data (write) / 0x52 addr (read); replies with a status byte.
`timescale 1ns/1ps
module uart_wb_master #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RX_TIMEOUT = 120000,
  parameter int WB_TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [7:0]      i_rx_data,
  input  logic            i_rx_stb,
  output logic [7:0]      o_tx_data,
  output logic            o_tx_stb,
  input  logic            i_tx_busy,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic [DW-1:0]   i_wb_data,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  output logic            o_busy,
  output logic            o_rx_drop
);

  localparam int NA  = AW / 8;
  localparam int ND  = DW / 8;
  localparam int RTW = $clog2(RX_TIMEOUT + 1);
  localparam int WTW = $clog2(WB_TIMEOUT + 1);

  localparam logic [RTW-1:0] RX_LAST = RTW'(RX_TIMEOUT - 1);
  localparam logic [WTW-1:0] WB_LAST = WTW'(WB_TIMEOUT - 1);
  localparam logic [1:0]     A_LAST  = 2'(NA - 1);
  localparam logic [1:0]     D_LAST  = 2'(ND - 1);
  localparam logic [2:0]     RD_LEN  = 3'(ND + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  typedef enum logic {
    TX_RDY,
    TX_HOLD
  } txph_t;

  state_t          st_q, st_d;
  txph_t           ph_q, ph_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [RTW-1:0]  rxto_q, rxto_d;
  logic [WTW-1:0]  wbto_q, wbto_d;
  logic [DW+7:0]   rsp_q, rsp_d;
  logic [2:0]      left_q, left_d;
  logic [1:0]      hold_q, hold_d;
  logic            txs_q, txs_d;
  logic [7:0]      txd_q, txd_d;

  function automatic logic [AW-1:0] shin_a(
    input logic [AW-1:0] v,
    input logic [7:0]    b
  );
    return (v << 8) | AW'(b);
  endfunction

  function automatic logic [DW-1:0] shin_d(
    input logic [DW-1:0] v,
    input logic [7:0]    b
  );
    return (v << 8) | DW'(b);
  endfunction

  always_comb begin
    st_d   = st_q;
    ph_d   = ph_q;
    we_d   = we_q;
    addr_d = addr_q;
    wdat_d = wdat_q;
    cnt_d  = cnt_q;
    rxto_d = rxto_q;
    wbto_d = wbto_q;
    rsp_d  = rsp_q;
    left_d = left_q;
    hold_d = hold_q;
    txs_d  = 1'b0;
    txd_d  = txd_q;

    // Busy may lag the strobe; ignore it on the strobe cycle itself.
    if (ph_q == TX_HOLD) begin
      if (hold_q == 2'd2 || (hold_q != 2'd0 && i_tx_busy)) begin
        ph_d = TX_RDY;
      end else begin
        hold_d = hold_q + 2'd1;
      end
    end

    unique case (st_q)
      S_IDLE: begin
        if (i_rx_stb && (i_rx_data == 8'h57 || i_rx_data == 8'h52)) begin
          we_d   = (i_rx_data == 8'h57);
          cnt_d  = 2'd0;
          rxto_d = '0;
          st_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (i_rx_stb) begin
          addr_d = shin_a(addr_q, i_rx_data);
          rxto_d = '0;
          if (cnt_q == A_LAST) begin
            cnt_d  = 2'd0;
            wbto_d = '0;
            st_d   = we_q ? S_DATA : S_BUS;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (rxto_q == RX_LAST) begin
          st_d = S_IDLE;
        end else begin
          rxto_d = rxto_q + RTW'(1);
        end
      end
      S_DATA: begin
        if (i_rx_stb) begin
          wdat_d = shin_d(wdat_q, i_rx_data);
          rxto_d = '0;
          if (cnt_q == D_LAST) begin
            cnt_d  = 2'd0;
            wbto_d = '0;
            st_d   = S_BUS;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (rxto_q == RX_LAST) begin
          st_d = S_IDLE;
        end else begin
          rxto_d = rxto_q + RTW'(1);
        end
      end
      S_BUS: begin
        if (i_wb_err) begin
          rsp_d  = {8'h45, {DW{1'b0}}};
          left_d = 3'd1;
          st_d   = S_RESP;
        end else if (i_wb_ack) begin
          rsp_d  = we_q ? {8'h4B, {DW{1'b0}}} : {8'h44, i_wb_data};
          left_d = we_q ? 3'd1 : RD_LEN;
          st_d   = S_RESP;
        end else if (wbto_q == WB_LAST) begin
          rsp_d  = {8'h45, {DW{1'b0}}};
          left_d = 3'd1;
          st_d   = S_RESP;
        end else begin
          wbto_d = wbto_q + WTW'(1);
        end
      end
      S_RESP: begin
        if (ph_q == TX_RDY && !i_tx_busy) begin
          txs_d  = 1'b1;
          txd_d  = rsp_q[DW+7 -: 8];
          rsp_d  = rsp_q << 8;
          left_d = left_q - 3'd1;
          ph_d   = TX_HOLD;
          hold_d = 2'd0;
          if (left_q == 3'd1) begin
            st_d = S_IDLE;
          end
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q   <= S_IDLE;
      ph_q   <= TX_RDY;
      we_q   <= 1'b0;
      addr_q <= '0;
      wdat_q <= '0;
      cnt_q  <= '0;
      rxto_q <= '0;
      wbto_q <= '0;
      rsp_q  <= '0;
      left_q <= '0;
      hold_q <= '0;
      txs_q  <= 1'b0;
      txd_q  <= '0;
    end else begin
      st_q   <= st_d;
      ph_q   <= ph_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      wdat_q <= wdat_d;
      cnt_q  <= cnt_d;
      rxto_q <= rxto_d;
      wbto_q <= wbto_d;
      rsp_q  <= rsp_d;
      left_q <= left_d;
      hold_q <= hold_d;
      txs_q  <= txs_d;
      txd_q  <= txd_d;
    end
  end

  assign o_wb_cyc  = (st_q == S_BUS);
  assign o_wb_stb  = (st_q == S_BUS);
  assign o_wb_we   = we_q;
  assign o_wb_addr = addr_q;
  assign o_wb_data = wdat_q;
  assign o_wb_sel  = {ND{st_q == S_BUS}};
  assign o_tx_stb  = txs_q;
  assign o_tx_data = txd_q;
  assign o_busy    = (st_q != S_IDLE);
  assign o_rx_drop = i_rx_stb && (st_q == S_BUS || st_q == S_RESP);

endmodule
